// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, ASCII display constants and the digit-to-character helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FMT   = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    return {4'h3, nib};
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-decimal converter, one input bit per clock, with
// signed mode, overflow flag and leading-zero-blanked ASCII for the LCD.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_md,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic [DIGITS*8-1:0]   ascii,
  output logic [7:0]            sign_chr,
  output logic                  neg,
  output logic                  ovf
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH);

  // Idle display shows a single '0' with every higher position blank.
  function automatic logic [DIGITS*8-1:0] zero_display();
    logic [DIGITS*8-1:0] r;
    for (int k = 0; k < DIGITS; k++)
      r[k*8 +: 8] = (k == 0) ? ASCII_ZERO : ASCII_SPACE;
    return r;
  endfunction

  localparam logic [DIGITS*8-1:0] ASCII_RESET = zero_display();

  state_t            state;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     scratch;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt;
  logic              neg_r;
  logic              ovf_r;
  logic [DIGITS*8-1:0] fmt_ascii;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (scratch[g*4 +: 4]),
      .dout (adj[g*4 +: 4])
    );
  end

  // Walk from the most significant digit down; a position prints once any
  // nonzero digit has been seen at or above it, and the units always print.
  always_comb begin
    logic seen;
    logic [3:0] nib;
    fmt_ascii = '0;
    seen      = 1'b0;
    nib       = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = scratch[k*4 +: 4];
      if (nib != 4'd0 || k == 0)
        seen = 1'b1;
      fmt_ascii[k*8 +: 8] = seen ? nibble_to_ascii(nib) : ASCII_SPACE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      ascii    <= ASCII_RESET;
      sign_chr <= ASCII_SPACE;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      mag      <= '0;
      scratch  <= '0;
      cnt      <= '0;
      neg_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            // Magnitude kept as WIDTH-bit unsigned so the most negative value is exact.
            mag     <= (signed_md && bin[WIDTH-1]) ? (~bin + 1'b1) : bin;
            neg_r   <= signed_md & bin[WIDTH-1];
            scratch <= '0;
            ovf_r   <= 1'b0;
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[BW-2:0], mag[WIDTH-1]};
          mag     <= {mag[WIDTH-2:0], 1'b0};
          ovf_r   <= ovf_r | adj[BW-1];
          if (cnt == '0)
            state <= FMT;
          else
            cnt <= cnt - 1'b1;
        end
        FMT: begin
          bcd      <= scratch;
          ascii    <= fmt_ascii;
          ovf      <= ovf_r;
          neg      <= neg_r;
          sign_chr <= neg_r ? ASCII_MINUS : ASCII_SPACE;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance,
// expected results queued at issue and checked by monitors on each done pulse.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [19:0] bcd;
    logic [39:0] ascii;
    logic [7:0]  sign;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, signed_md;
  logic [15:0] bin;
  logic        busy, done, neg, ovf;
  logic [19:0] bcd;
  logic [39:0] ascii;
  logic [7:0]  sign_chr;

  logic        start4, signed4;
  logic [15:0] bin4;
  logic        busy4, done4, neg4, ovf4;
  logic [15:0] bcd4;
  logic [31:0] ascii4;
  logic [7:0]  sign4;

  exp_t q5[$];
  exp_t q4[$];
  exp_t e5, e4;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_md(signed_md), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ascii(ascii),
    .sign_chr(sign_chr), .neg(neg), .ovf(ovf)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_md(signed4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .ascii(ascii4),
    .sign_chr(sign4), .neg(neg4), .ovf(ovf4)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitors pop one expected result per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q5.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done5: got done with empty queue, expected none");
      end else begin
        e5 = q5.pop_front();
        checkOutput("bcd5", bcd, e5.bcd);
        checkOutput("ascii5", ascii, e5.ascii);
        checkOutput("sign5", sign_chr, e5.sign);
        checkOutput("neg5", neg, e5.neg);
        checkOutput("ovf5", ovf, e5.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done4: got done with empty queue, expected none");
      end else begin
        e4 = q4.pop_front();
        checkOutput("bcd4", bcd4, e4.bcd[15:0]);
        checkOutput("ascii4", ascii4, e4.ascii[31:0]);
        checkOutput("sign4", sign4, e4.sign);
        checkOutput("neg4", neg4, e4.neg);
        checkOutput("ovf4", ovf4, e4.ovf);
      end
    end
  end

  // Issue one conversion, queue its expected result and measure latency.
  task automatic applyStimulus(input bit sel4, input logic sm, input logic [15:0] b,
                               input logic [19:0] eb, input logic [39:0] ea,
                               input logic en, input logic eo);
    exp_t e;
    int   lat;
    e.bcd   = eb;
    e.ascii = ea;
    e.sign  = en ? 8'h2D : 8'h20;
    e.neg   = en;
    e.ovf   = eo;
    if (sel4) q4.push_back(e);
    else      q5.push_back(e);
    @(negedge clk);
    if (sel4) begin start4 = 1'b1; signed4 = sm; bin4 = b; end
    else      begin start  = 1'b1; signed_md = sm; bin = b; end
    @(posedge clk);
    #1;
    // Inputs scrambled while busy must not disturb the result.
    if (sel4) begin start4 = 1'b0; signed4 = ~sm; bin4 = ~b; end
    else      begin start  = 1'b0; signed_md = ~sm; bin = ~b; end
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if ((sel4 ? done4 : done) === 1'b1) lat = i;
    end
    checkOutput(sel4 ? "latency4" : "latency5", lat, 17);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt, done_cnt;
    rst = 1'b1; start = 1'b0; signed_md = 1'b0; bin = '0;
    start4 = 1'b0; signed4 = 1'b0; bin4 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_bcd", bcd, 0);
    checkOutput("rst_ascii", ascii, "    0");
    checkOutput("rst_sign", sign_chr, 8'h20);
    checkOutput("rst_neg", neg, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_ascii4", ascii4, "   0");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 0, 16'hFFFF, 20'h65535, "65535", 0, 0);
    applyStimulus(0, 0, 16'd0,    20'h00000, "    0", 0, 0);
    applyStimulus(0, 0, 16'd407,  20'h00407, "  407", 0, 0);
    applyStimulus(0, 0, 16'd10000, 20'h10000, "10000", 0, 0);
    applyStimulus(0, 1, 16'h8000, 20'h32768, "32768", 1, 0);
    applyStimulus(0, 1, 16'hFFFF, 20'h00001, "    1", 1, 0);
    applyStimulus(0, 1, 16'hFF9C, 20'h00100, "  100", 1, 0);
    applyStimulus(0, 1, 16'h7FFF, 20'h32767, "32767", 0, 0);
    applyStimulus(0, 0, 16'h8000, 20'h32768, "32768", 0, 0);
    applyStimulus(0, 1, 16'd0,    20'h00000, "    0", 0, 0);

    applyStimulus(1, 0, 16'd12345, 20'h02345, "2345", 0, 1);
    applyStimulus(1, 0, 16'd9999,  20'h09999, "9999", 0, 0);
    applyStimulus(1, 0, 16'd10005, 20'h00005, "   5", 0, 1);
    applyStimulus(1, 1, 16'hFFF6,  20'h00010, "  10", 1, 0);

    // Extra start pulses while busy must be ignored.
    q5.push_back('{bcd: 20'h12345, ascii: "12345", sign: 8'h20, neg: 1'b0, ovf: 1'b0});
    @(negedge clk);
    start = 1'b1; signed_md = 1'b0; bin = 16'd12345;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    done_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (i == 3 || i == 10) begin start = 1'b1; bin = 16'd999; end
      if (i == 4 || i == 11) start = 1'b0;
    end
    checkOutput("busy_cycles", busy_cnt, 18);
    checkOutput("done_count", done_cnt, 1);

    // Reset mid-conversion returns to reset values without a done pulse.
    @(negedge clk);
    start = 1'b1; signed_md = 1'b0; bin = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_bcd", bcd, 0);
    checkOutput("midrst_ascii", ascii, "    0");
    checkOutput("midrst_sign", sign_chr, 8'h20);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    checkOutput("midrst_no_done", done_cnt, 0);
    applyStimulus(0, 0, 16'd407, 20'h00407, "  407", 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("q5_drained", q5.size(), 0);
    checkOutput("q4_drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
